// File: rtl/nexys_starship_spawner_if.sv
// Spawner control bus: game-state and kill inputs in, per-direction
// occupancy levels, spawn count and one-hot state flags out.
interface nexys_starship_spawner_if;
  logic       play_flag;
  logic       game_over;
  logic       kill_top;
  logic       kill_bottom;
  logic       kill_left;
  logic       kill_right;
  logic       top_monster_ctrl;
  logic       bottom_monster_ctrl;
  logic       left_monster_ctrl;
  logic       right_monster_ctrl;
  logic [7:0] spawn_count;
  logic       q_SP_Idle;
  logic       q_SP_Wait;
  logic       q_SP_Spawn;
  logic       q_SP_Halt;

  modport master (
    output play_flag, game_over, kill_top, kill_bottom, kill_left, kill_right,
    input  top_monster_ctrl, bottom_monster_ctrl, left_monster_ctrl, right_monster_ctrl,
    input  spawn_count, q_SP_Idle, q_SP_Wait, q_SP_Spawn, q_SP_Halt
  );

  modport slave (
    input  play_flag, game_over, kill_top, kill_bottom, kill_left, kill_right,
    output top_monster_ctrl, bottom_monster_ctrl, left_monster_ctrl, right_monster_ctrl,
    output spawn_count, q_SP_Idle, q_SP_Wait, q_SP_Spawn, q_SP_Halt
  );
endinterface

// File: rtl/nexys_starship_spawner.sv
// Monster spawner: LFSR-randomised gap timer and direction picker feeding the
// four per-direction monster state machines through registered level lines.
module nexys_starship_spawner #(
  parameter logic [19:0] TICK_DIV  = 20'd1000000,
  parameter logic [7:0]  MIN_GAP   = 8'd50,
  parameter logic [7:0]  GAP_MASK  = 8'h7F,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  nexys_starship_spawner_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_WAIT  = 4'b0010,
    S_SPAWN = 4'b0100,
    S_HALT  = 4'b1000
  } state_t;

  state_t      r_state, w_next;
  logic [15:0] r_lfsr, w_lfsr_nxt;
  logic [19:0] r_presc;
  logic [8:0]  r_gap, w_gap_sum, w_gap_load;
  logic [3:0]  r_occ;
  logic [7:0]  r_cnt;
  logic        w_tick;
  logic [3:0]  w_kill, w_occ_k, w_sel_1h;
  logic [1:0]  w_sel, w_idx;
  logic        w_found, w_spawn;

  // Occupancy/kill vectors are in clockwise order: 0 top, 1 right, 2 bottom, 3 left.
  assign w_kill = {bus.kill_left, bus.kill_bottom, bus.kill_right, bus.kill_top};

  always_comb begin
    w_lfsr_nxt = (r_lfsr == 16'h0) ? LFSR_SEED
               : ((r_lfsr >> 1) ^ (r_lfsr[0] ? 16'hB400 : 16'h0000));
    w_gap_sum  = {1'b0, MIN_GAP} + {1'b0, r_lfsr[7:0] & GAP_MASK};
    w_gap_load = (w_gap_sum == 9'd0) ? 9'd1 : w_gap_sum;
    w_tick     = (r_state == S_WAIT) && (r_presc == TICK_DIV - 20'd1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.play_flag && !bus.game_over) w_next = S_WAIT;
      S_WAIT: begin
        if (bus.game_over)                  w_next = S_HALT;
        else if (!bus.play_flag)            w_next = S_IDLE;
        else if (w_tick && r_gap <= 9'd1)   w_next = S_SPAWN;
      end
      S_SPAWN: begin
        if (bus.game_over)       w_next = S_HALT;
        else if (!bus.play_flag) w_next = S_IDLE;
        else                     w_next = S_WAIT;
      end
      S_HALT:  if (!bus.play_flag) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Kill lands before the search, so a just-killed slot is eligible again.
  always_comb begin
    w_occ_k = r_occ & ~w_kill;
    w_found = 1'b0;
    w_sel   = 2'd0;
    w_idx   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_lfsr[9:8] + 2'(i);
      if (!w_occ_k[w_idx]) begin
        w_found = 1'b1;
        w_sel   = w_idx;
      end
    end
    w_sel_1h = 4'b0001 << w_sel;
    w_spawn  = (r_state == S_SPAWN) && (w_next == S_WAIT) && w_found;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_lfsr  <= LFSR_SEED;
      r_presc <= '0;
      r_gap   <= '0;
      r_occ   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      r_lfsr  <= w_lfsr_nxt;
      r_presc <= (r_state == S_WAIT && !w_tick) ? r_presc + 20'd1 : 20'd0;
      if (w_next == S_WAIT && r_state != S_WAIT) r_gap <= w_gap_load;
      else if (w_tick)                           r_gap <= r_gap - 9'd1;
      if (w_next == S_IDLE || w_next == S_HALT) r_occ <= '0;
      else                                      r_occ <= w_occ_k | (w_spawn ? w_sel_1h : 4'b0000);
      if (w_next == S_IDLE)                   r_cnt <= '0;
      else if (w_spawn && r_cnt != 8'hFF)     r_cnt <= r_cnt + 8'd1;
    end
  end

  assign bus.top_monster_ctrl    = r_occ[0];
  assign bus.right_monster_ctrl  = r_occ[1];
  assign bus.bottom_monster_ctrl = r_occ[2];
  assign bus.left_monster_ctrl   = r_occ[3];
  assign bus.spawn_count         = r_cnt;
  assign bus.q_SP_Idle           = r_state[0];
  assign bus.q_SP_Wait           = r_state[1];
  assign bus.q_SP_Spawn          = r_state[2];
  assign bus.q_SP_Halt           = r_state[3];

endmodule

// File: tb/tb_nexys_starship_spawner.sv
// Bench for the starship spawner: directed vector table, async reset,
// LFSR sequence and randomised play against a behavioural model.
module tb_nexys_starship_spawner;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nexys_starship_spawner_if bus0();
  nexys_starship_spawner_if bus1();

  nexys_starship_spawner #(.TICK_DIV(20'd4), .MIN_GAP(8'd3), .GAP_MASK(8'h00), .LFSR_SEED(SEED))
    u_dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  // Second instance covers the random-gap path and the zero-gap clamp.
  nexys_starship_spawner #(.TICK_DIV(20'd3), .MIN_GAP(8'd0), .GAP_MASK(8'h03), .LFSR_SEED(SEED))
    u_dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input bit play, input bit go, input bit [3:0] kill);
    bus0.play_flag = play; bus0.game_over = go;
    bus1.play_flag = play; bus1.game_over = go;
    {bus0.kill_left, bus0.kill_bottom, bus0.kill_right, bus0.kill_top} = kill;
    {bus1.kill_left, bus1.kill_bottom, bus1.kill_right, bus1.kill_top} = kill;
  endtask

  function automatic int act_st(input int k);
    if (k == 0) return int'({bus0.q_SP_Halt, bus0.q_SP_Spawn, bus0.q_SP_Wait, bus0.q_SP_Idle});
    return int'({bus1.q_SP_Halt, bus1.q_SP_Spawn, bus1.q_SP_Wait, bus1.q_SP_Idle});
  endfunction

  function automatic int act_ctrl(input int k);
    if (k == 0) return int'({bus0.left_monster_ctrl, bus0.bottom_monster_ctrl,
                             bus0.right_monster_ctrl, bus0.top_monster_ctrl});
    return int'({bus1.left_monster_ctrl, bus1.bottom_monster_ctrl,
                 bus1.right_monster_ctrl, bus1.top_monster_ctrl});
  endfunction

  function automatic int act_cnt(input int k);
    if (k == 0) return int'(bus0.spawn_count);
    return int'(bus1.spawn_count);
  endfunction

  // ---- behavioural reference model (modes: 0 idle, 1 wait, 2 spawn, 3 halt)
  int        p_td[2] = '{4, 3};
  int        p_mg[2] = '{3, 0};
  int        p_gm[2] = '{0, 3};
  int        m_mode[2];
  bit [3:0]  m_occ[2];
  int        m_cnt[2];
  bit [15:0] m_lfsr[2];
  int        m_wc[2];
  int        m_wl[2];

  function automatic bit [15:0] lfsr_adv(input bit [15:0] v);
    int ex[4] = '{16, 14, 13, 11};
    bit [15:0] tap = '0;
    bit [15:0] r;
    if (v == 16'h0) return SEED;
    foreach (ex[j]) tap[ex[j]-1] = 1'b1;
    r = v >> 1;
    if (v[0]) r = r ^ tap;
    return r;
  endfunction

  function automatic int gap_cycles(input int k, input bit [15:0] lf);
    int g;
    g = p_mg[k] + (int'(lf[7:0]) & p_gm[k]);
    if (g == 0) g = 1;
    return g * p_td[k];
  endfunction

  task automatic m_reset(input int k);
    m_mode[k] = 0; m_occ[k] = '0; m_cnt[k] = 0; m_lfsr[k] = SEED; m_wc[k] = 0; m_wl[k] = 0;
  endtask

  task automatic m_step(input int k, input bit play, input bit go, input bit [3:0] kill);
    bit [15:0] cur;
    int pref, d;
    cur = m_lfsr[k];
    case (m_mode[k])
      0: begin
        m_occ[k] = '0; m_cnt[k] = 0;
        if (play && !go) begin m_mode[k] = 1; m_wl[k] = gap_cycles(k, cur); m_wc[k] = 0; end
      end
      1, 2: begin
        m_occ[k] = m_occ[k] & ~kill;
        if (go) begin m_mode[k] = 3; m_occ[k] = '0; end
        else if (!play) begin m_mode[k] = 0; m_occ[k] = '0; m_cnt[k] = 0; end
        else if (m_mode[k] == 1) begin
          m_wc[k]++;
          if (m_wc[k] == m_wl[k]) m_mode[k] = 2;
        end else begin
          pref = int'(cur[9:8]);
          for (int i = 0; i < 4; i++) begin
            d = (pref + i) % 4;
            if (!m_occ[k][d]) begin
              m_occ[k][d] = 1'b1;
              if (m_cnt[k] < 255) m_cnt[k]++;
              break;
            end
          end
          m_mode[k] = 1; m_wl[k] = gap_cycles(k, cur); m_wc[k] = 0;
        end
      end
      default: begin
        m_occ[k] = '0;
        if (!play) begin m_mode[k] = 0; m_cnt[k] = 0; end
      end
    endcase
    m_lfsr[k] = lfsr_adv(cur);
  endtask

  // ---- directed vector table (state one-hot: 1 idle, 2 wait, 4 spawn, 8 halt)
  typedef struct {
    bit       play;
    bit       go;
    bit [3:0] kill;   // {left, bottom, right, top}
    int       n;      // clock edges to apply
    int       st;
    int       cnt;
    int       pop;
  } vec_t;

  vec_t tbl[22];

  initial begin
    bit       r_play, r_go;
    bit [3:0] r_kill;

    tbl[0]  = '{1'b1, 1'b0, 4'h0,  1, 2, 0, 0};  // WAIT at cycle 1
    tbl[1]  = '{1'b1, 1'b0, 4'h0, 11, 2, 0, 0};  // cycle 12
    tbl[2]  = '{1'b1, 1'b0, 4'h0,  1, 4, 0, 0};  // SPAWN at cycle 13
    tbl[3]  = '{1'b1, 1'b0, 4'h0,  1, 2, 1, 1};  // one ctrl at cycle 14
    tbl[4]  = '{1'b1, 1'b0, 4'h0, 12, 4, 1, 1};
    tbl[5]  = '{1'b1, 1'b0, 4'h0,  1, 2, 2, 2};
    tbl[6]  = '{1'b1, 1'b0, 4'h0, 13, 2, 3, 3};
    tbl[7]  = '{1'b1, 1'b0, 4'h0, 13, 2, 4, 4};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 12, 4, 4, 4};  // 5th SPAWN, board full
    tbl[9]  = '{1'b1, 1'b0, 4'h0,  1, 2, 4, 4};
    tbl[10] = '{1'b1, 1'b0, 4'h0, 12, 4, 4, 4};
    tbl[11] = '{1'b1, 1'b0, 4'h8,  1, 2, 5, 4};  // kill_left in SPAWN
    tbl[12] = '{1'b1, 1'b0, 4'h0, 11, 2, 5, 4};  // cycle before next SPAWN
    tbl[13] = '{1'b1, 1'b1, 4'h0,  1, 8, 5, 0};  // game_over aborts
    tbl[14] = '{1'b1, 1'b1, 4'h0,  2, 8, 5, 0};
    tbl[15] = '{1'b0, 1'b0, 4'h0,  1, 1, 0, 0};
    tbl[16] = '{1'b0, 1'b0, 4'h0,  2, 1, 0, 0};
    tbl[17] = '{1'b1, 1'b0, 4'h0,  1, 2, 0, 0};
    tbl[18] = '{1'b1, 1'b0, 4'h0, 12, 4, 0, 0};
    tbl[19] = '{1'b1, 1'b0, 4'h0,  1, 2, 1, 1};
    tbl[20] = '{1'b1, 1'b0, 4'hF,  1, 2, 1, 0};  // kill clears in WAIT
    tbl[21] = '{1'b0, 1'b0, 4'h0,  1, 1, 0, 0};

    drive(1'b0, 1'b0, 4'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_state", act_st(0), 1);
    chk("reset_ctrl",  act_ctrl(0), 0);
    chk("reset_cnt",   act_cnt(0), 0);
    chk("reset_lfsr",  int'(u_dut0.r_lfsr), int'(SEED));
    rst = 1'b0;

    foreach (tbl[i]) begin
      drive(tbl[i].play, tbl[i].go, tbl[i].kill);
      repeat (tbl[i].n) @(posedge clk);
      @(negedge clk);
      chk($sformatf("vec%0d_state", i), act_st(0), tbl[i].st);
      chk($sformatf("vec%0d_cnt", i),   act_cnt(0), tbl[i].cnt);
      chk($sformatf("vec%0d_pop", i),   $countones(act_ctrl(0)), tbl[i].pop);
    end

    // Async reset in the middle of a gap with one monster on the board.
    drive(1'b1, 1'b0, 4'h0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("pre_rst_state", act_st(0), 2);
    chk("pre_rst_pop",   $countones(act_ctrl(0)), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_state", act_st(0), 1);
    chk("async_rst_ctrl",  act_ctrl(0), 0);
    chk("async_rst_cnt",   act_cnt(0), 0);
    chk("async_rst_lfsr",  int'(u_dut0.r_lfsr), int'(SEED));
    drive(1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst = 1'b0;

    // LFSR sequence from the seed.
    m_reset(0);
    for (int c = 0; c < 1000; c++) begin
      @(posedge clk);
      m_lfsr[0] = lfsr_adv(m_lfsr[0]);
      @(negedge clk);
      chk("lfsr_seq",     int'(u_dut0.r_lfsr), int'(m_lfsr[0]));
      chk("lfsr_nonzero", int'(u_dut0.r_lfsr != 16'h0), 1);
    end

    // Randomised play on both instances against the model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_reset(0);
    m_reset(1);
    for (int c = 0; c < 2500; c++) begin
      r_play = ($urandom % 64) != 0;
      r_go   = ($urandom % 150) == 0;
      for (int j = 0; j < 4; j++) r_kill[j] = ($urandom % 40) == 0;
      drive(r_play, r_go, r_kill);
      @(posedge clk);
      m_step(0, r_play, r_go, r_kill);
      m_step(1, r_play, r_go, r_kill);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rnd%0d_state", k), act_st(k), 1 << m_mode[k]);
        chk($sformatf("rnd%0d_ctrl", k),  act_ctrl(k), int'(m_occ[k]));
        chk($sformatf("rnd%0d_cnt", k),   act_cnt(k), m_cnt[k]);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/nexys_starship_spawner.md
Name: nexys_starship_spawner

Overview:
- Upstream stage of the per-direction monster state machines: top, bottom, left and right.
- Decides when and where a monster appears and drives one level-type control line per direction (top_monster_ctrl etc.); each control line feeds the matching monster SM.
- Timing and direction are pseudo-random: LFSR plus a tick-based gap counter.
- Spawning is gated by play_flag and stops on game_over.

Parameters:
- TICK_DIV, 1000000: clock cycles per game tick (10 ms at 100 MHz); width 20 bits; must be at least 2.
- MIN_GAP, 8'd50: minimum ticks between spawn attempts.
- GAP_MASK, 8'h7F: mask on LFSR[7:0] added to MIN_GAP for the random extra gap.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- Clk  in  1  system clock; single clock domain.
- Reset  in  1  asynchronous, active-high reset.
- play_flag  in  1  game running; level.
- game_over  in  1  end-of-game indication; level.
- kill_top, kill_bottom, kill_left, kill_right  in  1 each  one-cycle pulse: monster in that direction destroyed.
- top_monster_ctrl, bottom_monster_ctrl, left_monster_ctrl, right_monster_ctrl  out  1 each  registered occupancy/spawn level.
- spawn_count  out  8  successful spawns this game; saturating.
- q_SP_Idle, q_SP_Wait, q_SP_Spawn, q_SP_Halt  out  1 each  one-hot state outputs.

Behaviour:
- All outputs registered.
- Reset (asserted asynchronously, any time, including mid-gap or mid-spawn):
  - state = IDLE, so q_SP_Idle=1 and the other q_SP_* = 0.
  - all four ctrl = 0; spawn_count = 0.
  - LFSR = LFSR_SEED; prescaler = 0; gap counter = 0.
- Prescaler:
  - counts 0..TICK_DIV-1 in WAIT only; held at 0 in all other states.
  - tick is a one-cycle strobe when the count wraps to 0.
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1; advances every clock in every state.
  - If its value is ever 0, it reloads LFSR_SEED.
- IDLE:
  - ctrl all 0; spawn_count cleared to 0.
  - play_flag=1 and game_over=0 -> WAIT.
- WAIT:
  - On every entry to WAIT (from IDLE or SPAWN): gap = MIN_GAP + (LFSR[7:0] & GAP_MASK).
    - 9-bit sum, no overflow; gap = 0 is treated as 1.
  - gap decrements by 1 on each tick.
  - On the tick that brings gap to 0 -> SPAWN in the next cycle.
- SPAWN (exactly one cycle):
  - Preferred direction = LFSR[9:8]: 0 top, 1 right, 2 bottom, 3 left.
  - If the preferred direction is occupied, search clockwise top->right->bottom->left->top and take the first empty one.
  - Set that ctrl to 1 and increment spawn_count, saturating at 255.
  - If all four are occupied: no ctrl change, no increment.
  - Always -> WAIT.
- Kill:
  - kill_x in any state except IDLE clears x_ctrl; the change is visible the next cycle.
  - Kill on an empty direction is ignored.
  - Kill and SPAWN in the same cycle: the kill is applied first and occupancy is then re-evaluated, so the killed direction counts as empty. If selected, its ctrl ends at 1 and the spawn is counted.
- Halt and abort:
  - game_over=1 while in WAIT or SPAWN -> HALT next cycle. game_over takes priority over the spawn of that cycle: no spawn occurs.
  - HALT: all ctrl forced to 0; spawn_count held.
  - HALT -> IDLE when play_flag=0.
  - play_flag dropping in WAIT or SPAWN -> IDLE.
- Latency:
  - Spawn is visible on ctrl exactly 1 cycle after the SPAWN state cycle.
  - From entering WAIT to ctrl rising: gap*TICK_DIV + 2 cycles (±1 cycle for the prescaler phase, which is defined as starting at 0 on WAIT entry).
- No combinational output logic; state encoding is one-hot. An illegal state is recovered to IDLE on the next clock.

Test Plan:
- Reset mid-WAIT:
  - Setup: TICK_DIV=4, MIN_GAP=3, GAP_MASK=0.
  - Stimulus: Reset pulsed asynchronously, not on a clock edge.
  - Response: all ctrl=0, spawn_count=0, q_SP_Idle=1 immediately.
- Gap timing:
  - Setup: TICK_DIV=4, MIN_GAP=3, GAP_MASK=0.
  - Stimulus: play_flag=1 set at cycle 0.
  - Response: WAIT at cycle 1; SPAWN at cycle 13; exactly one ctrl rises at cycle 14; spawn_count=1.
- Saturation at four monsters:
  - Stimulus: no kills, run for 5 spawn periods.
  - Response: after 4 spawns all four ctrl=1; the 5th SPAWN changes nothing; spawn_count stays 4.
- Kill/spawn collision:
  - Setup: all four occupied.
  - Stimulus: kill_left pulsed in the SPAWN cycle.
  - Response: left_monster_ctrl stays 1; spawn_count increments by 1.
- Abort on game over:
  - Stimulus: game_over=1 in the cycle before SPAWN.
  - Response: no spawn; HALT; all ctrl=0 the next cycle; spawn_count held.
  - Then play_flag=0 -> IDLE, spawn_count=0.
- LFSR sequence:
  - Stimulus: compare the LFSR against a reference model from LFSR_SEED for 1000 cycles.
  - Response: exact match; the LFSR is never 0.
